// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encodings,
// opcode/funct constants and datapath select encodings.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    // Operation class handed to the ALU decoder
    typedef enum logic [2:0] {
        AOP_NONE  = 3'd0,
        AOP_ADD   = 3'd1,
        AOP_SUB   = 3'd2,
        AOP_FUNCT = 3'd3,
        AOP_IMM   = 3'd4
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Opcodes that only exist in the extended instruction set
    function automatic logic is_ext_op(input logic [5:0] opc);
        return (opc == OP_BNE) || (opc == OP_ANDI) || (opc == OP_ORI) || (opc == OP_JAL);
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Memory request/ready handshake between the controller and the memory side.
interface mips_mc_ctrl_if;
    logic mem_req;
    logic mem_ready;
    logic MemWrite;
    logic iord;

    modport master (output mem_req, output MemWrite, output iord, input mem_ready);
    modport slave  (input mem_req, input MemWrite, input iord, output mem_ready);
endinterface

// File: rtl/mips_alu_dec.sv
// ALU control decoder: maps the operation class plus op/funct to alucontrol
// and flags funct/op values that have no ALU meaning.
module mips_alu_dec
    import mips_mc_pkg::*;
#(
    parameter int EXT_OPS = 1
) (
    input  aluop_t     aluop,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       legal
);
    localparam logic EXT_EN = (EXT_OPS != 0);

    // Decode operation class into the ALU control word
    always_comb begin
        alucontrol = ALU_AND;
        legal      = 1'b1;
        case (aluop)
            AOP_NONE: alucontrol = ALU_AND;
            AOP_ADD:  alucontrol = ALU_ADD;
            AOP_SUB:  alucontrol = ALU_SUB;
            AOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: legal = 1'b0;
                endcase
            end
            AOP_IMM: begin
                case (op)
                    OP_ADDI: alucontrol = ALU_ADD;
                    OP_SLTI: alucontrol = ALU_SLT;
                    OP_ANDI: begin alucontrol = ALU_AND; legal = EXT_EN; end
                    OP_ORI:  begin alucontrol = ALU_OR;  legal = EXT_EN; end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main controller: decode and sequencing FSM with a
// memory ready handshake, wait-state timeout and sticky trap flags.
module mips_mc_ctrl
    import mips_mc_pkg::*;
#(
    parameter int EXT_OPS    = 1,
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic           clk,
    input  logic           reset,
    mips_mc_ctrl_if.master mem,
    input  logic [5:0]     op,
    input  logic [5:0]     funct,
    input  logic           zero,
    output logic           pcEnable,
    output logic           IRWrite,
    output logic           RegWrite,
    output logic           alusrca,
    output logic           MemtoReg,
    output logic           regDST,
    output logic           link,
    output logic           zeroext,
    output logic [1:0]     alusrcb,
    output logic [1:0]     pcsrc,
    output logic [2:0]     alucontrol,
    output logic           illegal_op,
    output logic           bus_error,
    output logic [3:0]     state_out
);
    localparam logic             EXT_EN     = (EXT_OPS != 0);
    localparam logic             TIMEOUT_EN = (WAIT_LIMIT != 0);
    localparam logic [CNT_W-1:0] LIMIT_C    = CNT_W'(WAIT_LIMIT);

    state_t           state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic             illegal_op_r, bus_error_r;
    logic             set_illegal_s, set_bus_error_s, timeout_s;
    logic             mem_req_s, mem_write_s, ir_write_s, pc_enable_s, reg_write_s;
    logic             alusrca_s, iord_s, memtoreg_s, regdst_s, link_s, zeroext_s;
    logic [1:0]       alusrcb_s, pcsrc_s;
    aluop_t           aluop_s;
    logic [2:0]       alu_ctl_s;
    logic             alu_legal_s;

    mips_alu_dec #(.EXT_OPS(EXT_OPS)) u_alu_dec (
        .aluop      (aluop_s),
        .op         (op),
        .funct      (funct),
        .alucontrol (alu_ctl_s),
        .legal      (alu_legal_s)
    );

    // A request stalled at the wait limit with no ready this cycle gives up
    assign timeout_s = TIMEOUT_EN && mem_req_s && !mem.mem_ready && (cnt_r == LIMIT_C);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= S_FETCH;
        else        state_r <= state_next_s;
    end

    // Next-state logic and trap cause detection
    always_comb begin
        state_next_s    = state_r;
        set_illegal_s   = 1'b0;
        set_bus_error_s = 1'b0;
        case (state_r)
            S_FETCH, S_MEMRD, S_MEMWR: begin
                if (mem.mem_ready) begin
                    if (state_r == S_FETCH)      state_next_s = S_DECODE;
                    else if (state_r == S_MEMRD) state_next_s = S_MEMWB;
                    else                         state_next_s = S_FETCH;
                end else if (timeout_s) begin
                    state_next_s    = S_TRAP;
                    set_bus_error_s = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            S_DECODE: begin
                if (!EXT_EN && is_ext_op(op)) begin
                    state_next_s  = S_TRAP;
                    set_illegal_s = 1'b1;
                end else begin
                    case (op)
                        OP_LW, OP_SW:                      state_next_s = S_MEMADR;
                        OP_RTYPE:                          state_next_s = S_EXEC;
                        OP_BEQ, OP_BNE:                    state_next_s = S_BRANCH;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next_s = S_IEXEC;
                        OP_J, OP_JAL:                      state_next_s = S_JUMP;
                        default: begin
                            state_next_s  = S_TRAP;
                            set_illegal_s = 1'b1;
                        end
                    endcase
                end
            end
            S_MEMADR: begin
                if (op == OP_LW) state_next_s = S_MEMRD;
                else             state_next_s = S_MEMWR;
            end
            S_EXEC: begin
                if (alu_legal_s) begin
                    state_next_s = S_ALUWB;
                end else begin
                    state_next_s  = S_TRAP;
                    set_illegal_s = 1'b1;
                end
            end
            S_IEXEC:                          state_next_s = S_IWB;
            S_MEMWB, S_ALUWB, S_BRANCH,
            S_IWB, S_JUMP:                    state_next_s = S_FETCH;
            S_TRAP:                           state_next_s = S_TRAP;
            default: begin
                state_next_s  = S_TRAP;
                set_illegal_s = 1'b1;
            end
        endcase
    end

    // Per-state datapath controls before reset gating
    always_comb begin
        mem_req_s   = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        pc_enable_s = 1'b0;
        reg_write_s = 1'b0;
        alusrca_s   = 1'b0;
        iord_s      = 1'b0;
        memtoreg_s  = 1'b0;
        regdst_s    = 1'b0;
        link_s      = 1'b0;
        zeroext_s   = 1'b0;
        alusrcb_s   = SRCB_REG;
        pcsrc_s     = PCSRC_ALU;
        aluop_s     = AOP_NONE;
        case (state_r)
            S_FETCH: begin
                mem_req_s   = 1'b1;
                alusrcb_s   = SRCB_FOUR;
                aluop_s     = AOP_ADD;
                ir_write_s  = mem.mem_ready;
                pc_enable_s = mem.mem_ready;
            end
            S_DECODE: begin
                alusrcb_s = SRCB_IMM_SH;
                aluop_s   = AOP_ADD;
            end
            S_MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = SRCB_IMM;
                aluop_s   = AOP_ADD;
            end
            S_MEMRD: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s = 1'b1;
                memtoreg_s  = 1'b1;
            end
            S_MEMWR: begin
                mem_req_s   = 1'b1;
                iord_s      = 1'b1;
                // The write strobe is withdrawn on the cycle the access is abandoned
                mem_write_s = !timeout_s;
            end
            S_EXEC: begin
                alusrca_s = 1'b1;
                aluop_s   = AOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                regdst_s    = 1'b1;
            end
            S_BRANCH: begin
                alusrca_s   = 1'b1;
                aluop_s     = AOP_SUB;
                pcsrc_s     = PCSRC_ALUOUT;
                pc_enable_s = (op == OP_BEQ) ? zero : !zero;
            end
            S_IEXEC: begin
                alusrca_s = 1'b1;
                alusrcb_s = SRCB_IMM;
                aluop_s   = AOP_IMM;
                zeroext_s = (op == OP_ANDI) || (op == OP_ORI);
            end
            S_IWB: begin
                reg_write_s = 1'b1;
                zeroext_s   = (op == OP_ANDI) || (op == OP_ORI);
            end
            S_JUMP: begin
                pcsrc_s     = PCSRC_JUMP;
                pc_enable_s = 1'b1;
                reg_write_s = (op == OP_JAL);
                link_s      = (op == OP_JAL);
            end
            S_TRAP:  mem_req_s = 1'b0;
            default: mem_req_s = 1'b0;
        endcase
    end

    // Wait counter: restarts on any state change or ready, counts stalled requests
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                       cnt_r <= {CNT_W{1'b0}};
        else if (mem.mem_ready || (state_next_s != state_r)) cnt_r <= {CNT_W{1'b0}};
        else if (mem_req_s)                               cnt_r <= cnt_r + CNT_W'(1);
        else                                              cnt_r <= cnt_r;
    end

    // Sticky trap causes, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_op_r <= 1'b0;
            bus_error_r  <= 1'b0;
        end else begin
            illegal_op_r <= illegal_op_r | set_illegal_s;
            bus_error_r  <= bus_error_r | set_bus_error_s;
        end
    end

    // Enables and the request are held off while reset is asserted
    assign mem.mem_req  = mem_req_s & reset;
    assign mem.MemWrite = mem_write_s & reset;
    assign mem.iord     = iord_s;
    assign IRWrite      = ir_write_s & reset;
    assign pcEnable     = pc_enable_s & reset;
    assign RegWrite     = reg_write_s & reset;
    assign alusrca      = alusrca_s;
    assign MemtoReg     = memtoreg_s;
    assign regDST       = regdst_s;
    assign link         = link_s;
    assign zeroext      = zeroext_s;
    assign alusrcb      = alusrcb_s;
    assign pcsrc        = pcsrc_s;
    assign alucontrol   = alu_ctl_s;
    assign illegal_op   = illegal_op_r;
    assign bus_error    = bus_error_r;
    assign state_out    = state_r;
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed testbench for mips_mc_ctrl: one instance with the extended
// instruction set, one without, sharing the same stimulus.
module tb_mips_mc_ctrl;
    import mips_mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    int         n_checks = 0;
    int         n_fail = 0;

    mips_mc_ctrl_if bus_e ();
    mips_mc_ctrl_if bus_b ();

    logic       e_pcEnable, e_IRWrite, e_RegWrite, e_alusrca, e_MemtoReg, e_regDST;
    logic       e_link, e_zeroext, e_illegal_op, e_bus_error;
    logic [1:0] e_alusrcb, e_pcsrc;
    logic [2:0] e_alucontrol;
    logic [3:0] e_state;
    logic       b_pcEnable, b_IRWrite, b_RegWrite, b_alusrca, b_MemtoReg, b_regDST;
    logic       b_link, b_zeroext, b_illegal_op, b_bus_error;
    logic [1:0] b_alusrcb, b_pcsrc;
    logic [2:0] b_alucontrol;
    logic [3:0] b_state;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.EXT_OPS(1), .WAIT_LIMIT(15), .CNT_W(4)) dut_e (
        .clk(clk), .reset(reset), .mem(bus_e), .op(op), .funct(funct), .zero(zero),
        .pcEnable(e_pcEnable), .IRWrite(e_IRWrite), .RegWrite(e_RegWrite),
        .alusrca(e_alusrca), .MemtoReg(e_MemtoReg), .regDST(e_regDST), .link(e_link),
        .zeroext(e_zeroext), .alusrcb(e_alusrcb), .pcsrc(e_pcsrc),
        .alucontrol(e_alucontrol), .illegal_op(e_illegal_op), .bus_error(e_bus_error),
        .state_out(e_state)
    );

    mips_mc_ctrl #(.EXT_OPS(0), .WAIT_LIMIT(15), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .mem(bus_b), .op(op), .funct(funct), .zero(zero),
        .pcEnable(b_pcEnable), .IRWrite(b_IRWrite), .RegWrite(b_RegWrite),
        .alusrca(b_alusrca), .MemtoReg(b_MemtoReg), .regDST(b_regDST), .link(b_link),
        .zeroext(b_zeroext), .alusrcb(b_alusrcb), .pcsrc(b_pcsrc),
        .alucontrol(b_alucontrol), .illegal_op(b_illegal_op), .bus_error(b_bus_error),
        .state_out(b_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic v);
        bus_e.mem_ready = v;
        bus_b.mem_ready = v;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_ready(1'b0);
        zero  = 1'b0;
        op    = 6'd0;
        funct = 6'd0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        do_reset();
        #1;
        got = 32'({e_state, bus_e.mem_req, e_illegal_op, e_bus_error});
        exp = 32'({4'd0, 1'b1, 1'b0, 1'b0});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_release: got %b want %b", got, exp); end
        tick();
        got = 32'({e_state, bus_e.mem_req, e_IRWrite, e_pcEnable});
        exp = 32'({4'd0, 1'b1, 1'b0, 1'b0});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL fetch_hold: got %b want %b", got, exp); end
        reset = 1'b0;
        #1;
        got = 32'({e_state, bus_e.mem_req, bus_e.MemWrite, e_IRWrite, e_pcEnable, e_RegWrite});
        exp = 32'({4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_low: got %b want %b", got, exp); end
        set_ready(1'b1);
        tick();
        got = 32'({e_state, bus_e.mem_req, e_IRWrite, e_pcEnable, e_illegal_op, e_bus_error});
        exp = 32'({4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_held_ready: got %b want %b", got, exp); end
        set_ready(1'b0);
        reset = 1'b1;
        tick();
        got = 32'({e_state, bus_e.mem_req, bus_e.iord, e_alusrcb, e_alucontrol});
        exp = 32'({4'd0, 1'b1, 1'b0, 2'b01, 3'b010});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL fetch_after_release: got %b want %b", got, exp); end
    endtask

    task automatic test_rtype();
        logic [31:0] got, exp;
        logic [5:0] fn [5];
        logic [2:0] ac [5];
        fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        ac = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        for (int i = 0; i < 5; i++) begin
            do_reset();
            op = 6'b000000; funct = fn[i]; set_ready(1'b1);
            #1;
            got = 32'({e_state, bus_e.mem_req, e_IRWrite, e_pcEnable, e_alusrca, e_alusrcb, e_alucontrol, e_pcsrc});
            exp = 32'({4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 2'b00});
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL rtype%0d_fetch: got %b want %b", i, got, exp); end
            tick();
            got = 32'({e_state, bus_e.mem_req, e_alusrca, e_alusrcb, e_alucontrol});
            exp = 32'({4'd1, 1'b0, 1'b0, 2'b11, 3'b010});
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL rtype%0d_decode: got %b want %b", i, got, exp); end
            tick();
            got = 32'({e_state, e_alusrca, e_alusrcb, e_alucontrol, e_RegWrite});
            exp = 32'({4'd6, 1'b1, 2'b00, ac[i], 1'b0});
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL rtype%0d_exec: got %b want %b", i, got, exp); end
            tick();
            got = 32'({e_state, e_RegWrite, e_regDST, e_MemtoReg, e_link, bus_e.mem_req});
            exp = 32'({4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL rtype%0d_aluwb: got %b want %b", i, got, exp); end
            tick();
            got = 32'({e_state, bus_e.mem_req, e_illegal_op});
            exp = 32'({4'd0, 1'b1, 1'b0});
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL rtype%0d_refetch: got %b want %b", i, got, exp); end
        end
        // Undefined funct traps out of EXEC
        do_reset();
        op = 6'b000000; funct = 6'b000111; set_ready(1'b1);
        tick();
        tick();
        got = 32'({e_state, e_illegal_op});
        exp = 32'({4'd6, 1'b0});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL badfunct_exec: got %b want %b", got, exp); end
        tick();
        tick();
        got = 32'({e_state, e_illegal_op, e_bus_error, bus_e.mem_req, e_RegWrite, e_pcEnable});
        exp = 32'({4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL badfunct_trap: got %b want %b", got, exp); end
    endtask

    task automatic test_load();
        logic [31:0] got, exp;
        do_reset();
        op = 6'b100011; set_ready(1'b1);
        tick();
        tick();
        got = 32'({e_state, e_alusrca, e_alusrcb, e_alucontrol, bus_e.mem_req});
        exp = 32'({4'd2, 1'b1, 2'b10, 3'b010, 1'b0});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL lw_memadr: got %b want %b", got, exp); end
        set_ready(1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) set_ready(1'b1);
            #1;
            got = 32'({e_state, bus_e.mem_req, bus_e.iord, bus_e.MemWrite, e_RegWrite});
            exp = 32'({4'd3, 1'b1, 1'b1, 1'b0, 1'b0});
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL lw_memrd%0d: got %b want %b", k, got, exp); end
            tick();
        end
        set_ready(1'b0);
        got = 32'({e_state, e_RegWrite, e_MemtoReg, e_regDST});
        exp = 32'({4'd4, 1'b1, 1'b1, 1'b0});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL lw_memwb: got %b want %b", got, exp); end
        tick();
        got = 32'({e_state, bus_e.mem_req});
        exp = 32'({4'd0, 1'b1});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL lw_refetch: got %b want %b", got, exp); end
    endtask

    task automatic test_branch();
        logic [31:0] got, exp;
        logic [5:0] bop [4];
        logic       bz [4];
        logic       bpe [4];
        bop = '{6'b000101, 6'b000101, 6'b000100, 6'b000100};
        bz  = '{1'b0, 1'b1, 1'b1, 1'b0};
        bpe = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            do_reset();
            op = bop[i]; set_ready(1'b1);
            tick();
            tick();
            zero = bz[i];
            #1;
            got = 32'({e_state, e_pcEnable, e_pcsrc, e_alucontrol, e_alusrca, e_alusrcb, e_RegWrite});
            exp = 32'({4'd8, bpe[i], 2'b01, 3'b110, 1'b1, 2'b00, 1'b0});
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL branch%0d: got %b want %b", i, got, exp); end
            tick();
            got = 32'({e_state});
            exp = 32'({4'd0});
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL branch%0d_refetch: got %b want %b", i, got, exp); end
        end
    endtask

    task automatic test_imm();
        logic [31:0] got, exp;
        logic [5:0] iop [4];
        logic [2:0] iac [4];
        logic       izx [4];
        iop = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
        iac = '{3'b010, 3'b000, 3'b001, 3'b111};
        izx = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            do_reset();
            op = iop[i]; set_ready(1'b1);
            tick();
            tick();
            got = 32'({e_state, e_alusrca, e_alusrcb, e_alucontrol, e_zeroext, e_RegWrite});
            exp = 32'({4'd9, 1'b1, 2'b10, iac[i], izx[i], 1'b0});
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL imm%0d_iexec: got %b want %b", i, got, exp); end
            tick();
            got = 32'({e_state, e_RegWrite, e_regDST, e_MemtoReg, e_zeroext});
            exp = 32'({4'd10, 1'b1, 1'b0, 1'b0, izx[i]});
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL imm%0d_iwb: got %b want %b", i, got, exp); end
            tick();
            got = 32'({e_state});
            exp = 32'({4'd0});
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL imm%0d_refetch: got %b want %b", i, got, exp); end
        end
    endtask

    task automatic test_jump();
        logic [31:0] got, exp;
        logic [5:0] jop [2];
        logic       jl [2];
        jop = '{6'b000010, 6'b000011};
        jl  = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            do_reset();
            op = jop[i]; set_ready(1'b1);
            tick();
            tick();
            got = 32'({e_state, e_pcsrc, e_pcEnable, e_RegWrite, e_link});
            exp = 32'({4'd11, 2'b10, 1'b1, jl[i], jl[i]});
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL jump%0d: got %b want %b", i, got, exp); end
            tick();
            got = 32'({e_state});
            exp = 32'({4'd0});
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL jump%0d_refetch: got %b want %b", i, got, exp); end
        end
    endtask

    task automatic test_ext_disabled();
        logic [31:0] got, exp;
        logic [5:0] xop [4];
        xop = '{6'b000011, 6'b000101, 6'b001100, 6'b001101};
        for (int i = 0; i < 4; i++) begin
            do_reset();
            op = xop[i]; set_ready(1'b1);
            tick();
            got = 32'({b_state, b_illegal_op});
            exp = 32'({4'd1, 1'b0});
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL noext%0d_decode: got %b want %b", i, got, exp); end
            tick();
            for (int k = 0; k < 3; k++) begin
                got = 32'({b_state, b_illegal_op, b_bus_error, bus_b.mem_req, b_pcEnable, b_IRWrite, b_RegWrite});
                exp = 32'({4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
                n_checks++;
                if (got !== exp) begin n_fail++; $display("FAIL noext%0d_trap%0d: got %b want %b", i, k, got, exp); end
                tick();
            end
        end
        // Same jal is legal on the extended instance
        do_reset();
        op = 6'b000011; set_ready(1'b1);
        tick();
        tick();
        got = 32'({e_state, e_illegal_op, b_state});
        exp = 32'({4'd11, 1'b0, 4'd12});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL jal_ext_vs_base: got %b want %b", got, exp); end
    endtask

    task automatic test_store_timeout();
        logic [31:0] got, exp;
        // Zero-wait store: four cycles, strobe with ready
        do_reset();
        op = 6'b101011; set_ready(1'b1);
        tick();
        set_ready(1'b0);
        tick();
        tick();
        set_ready(1'b1);
        #1;
        got = 32'({e_state, bus_e.mem_req, bus_e.MemWrite, bus_e.iord});
        exp = 32'({4'd5, 1'b1, 1'b1, 1'b1});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL sw_memwr: got %b want %b", got, exp); end
        tick();
        got = 32'({e_state, e_bus_error});
        exp = 32'({4'd0, 1'b0});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL sw_refetch: got %b want %b", got, exp); end
        // Store never acknowledged: 15 waits then bus error
        do_reset();
        op = 6'b101011; set_ready(1'b1);
        tick();
        set_ready(1'b0);
        tick();
        tick();
        for (int k = 0; k < 16; k++) begin
            got = 32'({e_state, bus_e.mem_req, bus_e.MemWrite, e_bus_error});
            exp = 32'({4'd5, 1'b1, (k < 15), 1'b0});
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL sw_wait%0d: got %b want %b", k, got, exp); end
            tick();
        end
        set_ready(1'b1);
        for (int k = 0; k < 2; k++) begin
            got = 32'({e_state, e_bus_error, e_illegal_op, bus_e.mem_req, bus_e.MemWrite});
            exp = 32'({4'd12, 1'b1, 1'b0, 1'b0, 1'b0});
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL sw_timeout%0d: got %b want %b", k, got, exp); end
            tick();
        end
        // Fetch also times out
        do_reset();
        for (int k = 0; k < 16; k++) tick();
        got = 32'({e_state, e_bus_error, bus_e.mem_req});
        exp = 32'({4'd12, 1'b1, 1'b0});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL fetch_timeout: got %b want %b", got, exp); end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] got, exp;
        do_reset();
        op = 6'b101011; set_ready(1'b1);
        tick();
        set_ready(1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        got = 32'({e_state, bus_e.mem_req, bus_e.MemWrite});
        exp = 32'({4'd0, 1'b0, 1'b0});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_mid_write: got %b want %b", got, exp); end
        tick();
        reset = 1'b1;
        #1;
        got = 32'({e_state, bus_e.mem_req, bus_e.MemWrite, bus_e.iord});
        exp = 32'({4'd0, 1'b1, 1'b0, 1'b0});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL after_abandon: got %b want %b", got, exp); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, exp;
        do_reset();
        op = 6'b000010;
        for (int k = 0; k < 2; k++) begin
            got = 32'({e_state, bus_e.mem_req, e_IRWrite, e_pcEnable});
            exp = 32'({4'd0, 1'b1, 1'b0, 1'b0});
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL b2b_fetchwait%0d: got %b want %b", k, got, exp); end
            tick();
        end
        set_ready(1'b1);
        #1;
        got = 32'({e_state, e_IRWrite, e_pcEnable});
        exp = 32'({4'd0, 1'b1, 1'b1});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL b2b_fetch_j: got %b want %b", got, exp); end
        tick();
        tick();
        got = 32'({e_state, e_pcEnable});
        exp = 32'({4'd11, 1'b1});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL b2b_jump: got %b want %b", got, exp); end
        tick();
        op = 6'b000000; funct = 6'b100010;
        #1;
        got = 32'({e_state, e_IRWrite});
        exp = 32'({4'd0, 1'b1});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL b2b_fetch_sub: got %b want %b", got, exp); end
        tick();
        tick();
        got = 32'({e_state, e_alucontrol});
        exp = 32'({4'd6, 3'b110});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL b2b_exec_sub: got %b want %b", got, exp); end
        tick();
        tick();
        got = 32'({e_state, e_illegal_op, e_bus_error});
        exp = 32'({4'd0, 1'b0, 1'b0});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL b2b_end: got %b want %b", got, exp); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        op    = 6'd0;
        funct = 6'd0;
        zero  = 1'b0;
        set_ready(1'b0);
        test_reset();
        test_rtype();
        test_load();
        test_branch();
        test_imm();
        test_jump();
        test_ext_disabled();
        test_store_timeout();
        test_reset_mid_write();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
